sfm_cast_out_ctrl: RTL
======================

# sfm_cast_out_ctrl

Job controller and output packer for the softmax FP→integer cast stage. It latches the cast configuration once per job and drives it to the combinational FP→int cast unit, so the configuration is stable for the whole job. It counts the cast unit's output beats and packs the narrow integer results, NUM_ROWS×INT_WIDTH bits each, into full DATA_WIDTH words. It flushes a final partial word and signals job completion to the streamer/FSM.

## Interface
Parameters:
- DATA_WIDTH, DATA_W, stream width in bits
- FPFORMAT, FPFORMAT_IN, input float format; FP_WIDTH = fpnew_pkg::fp_width(FPFORMAT)
- INT_WIDTH, INT_W, integer result width
- LEN_WIDTH, 32, width of the beat counter

Derived values:
- NUM_ROWS = DATA_WIDTH/FP_WIDTH
- NARROW_W = NUM_ROWS×INT_WIDTH
- PACK_RATIO = FP_WIDTH/INT_WIDTH, which must be a power of two ≥1

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear, returns to IDLE
- start_i  in  1  single-cycle job start
- cfg_i  in  cast_ctrl_t  configuration (enable, is_signed, int_bits), sampled on start
- len_i  in  LEN_WIDTH  number of input beats in the job, sampled on start
- ctrl_o  out  cast_ctrl_t  latched configuration driven to the cast unit
- busy_o  out  1  high from accepted start until done
- done_o  out  1  single-cycle completion pulse
- cast_i  hwpe_stream sink  DATA_WIDTH  output of the cast unit
- stream_o  hwpe_stream source  DATA_WIDTH  packed output

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i latches cfg_i into ctrl_o and len_i into rem_q.
  - The slot counter is cleared.
  - If len_i == 0 → DONE, otherwise → RUN.
  - start_i in any other state is ignored.
- Effective ratio R = ctrl_o.enable ? PACK_RATIO : 1.
- RUN accepts beats on cast_i.valid && cast_i.ready:
  - Data bits [NARROW_W-1:0] are written into slot `slot_q` of pack_q.
  - The strobe for that slot is strb[NARROW_W/8-1:0].
  - If enable = 0, the full DATA_WIDTH data and strobe pass through as one slot.
  - `slot_q` increments modulo R and `rem_q` decrements.
- A word is complete when the accepted beat fills slot R-1, or when it is the last beat (rem_q == 1).
  - The completed word, including the slot just written, moves into out_q and out_valid_q is set.
  - Unfilled slots carry zero data and zero strobe.
  - `slot_q` returns to 0.
- Last beat accepted → DRAIN.
- DRAIN: wait until out_valid_q is clear or is consumed this cycle, then → DONE.
- DONE: done_o = 1 for exactly one cycle, ctrl_o is held, → IDLE.
- ctrl_o keeps its last value in IDLE.
- cast_i.ready:
  - = 1 in RUN when the beat does not complete a word.
  - = (!out_valid_q || stream_o.ready) in RUN when the beat completes a word.
  - = 0 in every other state.
- stream_o.valid = out_valid_q; it is cleared on stream_o.valid && stream_o.ready unless a new word loads in the same cycle.
- Beats arriving on cast_i beyond len are not accepted, because ready = 0 outside RUN.
- clear_i has priority over everything else: it forces IDLE and clears out_valid_q, slot_q, rem_q and pack_q. ctrl_o goes to '0.

## Timing
- Reset values:
  - state = IDLE
  - ctrl_o = '0
  - busy_o = 0, done_o = 0
  - stream_o.valid = 0, data = 0, strb = 0
  - cast_i.ready = 0
- Latency: one cycle from acceptance of the word-completing beat to stream_o.valid.
- Throughput: one input beat per cycle. With stream_o.ready held high, output is one word every R cycles.
- Data on stream_o is stable while valid && !ready. valid never drops without a handshake, except on clear_i or reset.
- In the same cycle, output handshake plus a new word-completing input loads out_q with no bubble.
- done_o asserts the cycle after the final output handshake, or the cycle after start when len = 0.
- busy_o = (state != IDLE).
- Reset asserted mid-job aborts immediately, with no done pulse.

## Structure
- cast_ctrl_t stays in sfm_pkg. Add cast_out_ctrl_state_e (IDLE/RUN/DRAIN/DONE) to sfm_pkg.
- Derived localparams are computed in-module.
- A single module, no sub-modules. The output register is inlined as a one-entry stage, not a separate FIFO instance.

## Test plan
Configuration for all tests: DATA_WIDTH=256, FP16, INT8, so NUM_ROWS=16, NARROW_W=128, R=2.
- Basic pack: start with len=4, enable=1, sink always ready, beats data low halves 0xA…, 0xB…, 0xC…, 0xD…. Required: 2 output words {B,A} and {D,C} with strb all ones, then done_o pulses one cycle after the second handshake.
- Odd length: len=3. Required: second word = {0, C} with strb[31:16]=0, then done pulses.
- Backpressure: stream_o.ready=0 for 5 cycles mid-job. Required: cast_i.ready drops on the word-completing beat, stream_o data is stable, and no beat is lost or duplicated.
- Passthrough: enable=0, len=3. Required: 3 output words equal to the inputs including strobe, and ctrl_o.enable=0 throughout.
- Edge cases:
  - len=0: done the cycle after start and no output.
  - start_i during RUN: ignored, with ctrl_o unchanged.
- Clear mid-job: clear_i after 1 beat. Required: IDLE next cycle, valid=0, no done, and a following job runs correctly.

Source files
------------

// File: rtl/sfm_pkg.sv
// Shared softmax types: cast configuration bundle and
// the cast-output controller state encoding.
package sfm_pkg;

    typedef struct packed {
        logic       enable;
        logic       is_signed;
        logic [5:0] int_bits;
    } cast_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } cast_out_ctrl_state_e;

endpackage

// File: rtl/sfm_cast_out_ctrl.sv
// Job controller and output packer for the softmax FP->int cast stage.
// Holds cast config per job, packs narrow results into full stream words.
module sfm_cast_out_ctrl
    import sfm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned FP_WIDTH   = 16,
    parameter int unsigned INT_WIDTH  = 8,
    parameter int unsigned LEN_WIDTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  cast_ctrl_t              cfg_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output cast_ctrl_t              ctrl_o,
    output logic                    busy_o,
    output logic                    done_o,
    input  logic                    cast_valid_i,
    input  logic [DATA_WIDTH-1:0]   cast_data_i,
    input  logic [DATA_WIDTH/8-1:0] cast_strb_i,
    output logic                    cast_ready_o,
    output logic                    stream_valid_o,
    output logic [DATA_WIDTH-1:0]   stream_data_o,
    output logic [DATA_WIDTH/8-1:0] stream_strb_o,
    input  logic                    stream_ready_i
);

    localparam int unsigned NUM_ROWS   = DATA_WIDTH / FP_WIDTH;
    localparam int unsigned NARROW_W   = NUM_ROWS * INT_WIDTH;
    localparam int unsigned NARROW_B   = NARROW_W / 8;
    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int unsigned PACK_RATIO = FP_WIDTH / INT_WIDTH;
    localparam int unsigned SLOT_W     = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;

    cast_out_ctrl_state_e   state_q;
    cast_ctrl_t             ctrl_q;
    logic [LEN_WIDTH-1:0]   rem_q;
    logic [SLOT_W-1:0]      slot_q;
    logic [DATA_WIDTH-1:0]  pack_q;
    logic [STRB_W-1:0]      pstrb_q;
    logic [DATA_WIDTH-1:0]  out_q;
    logic [STRB_W-1:0]      ostrb_q;
    logic                   out_valid_q;

    logic                   last_beat;
    logic                   fills;
    logic                   completes;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  word_d;
    logic [STRB_W-1:0]      wstrb_d;

    assign last_beat = (rem_q == LEN_WIDTH'(1));
    // With packing disabled every beat is a whole word on its own.
    assign fills     = !ctrl_q.enable || (slot_q == SLOT_W'(PACK_RATIO - 1));
    assign completes = last_beat || fills;

    assign cast_ready_o = (state_q == RUN) &&
                          (!completes || !out_valid_q || stream_ready_i);
    assign accept       = cast_valid_i && cast_ready_o;

    assign ctrl_o         = ctrl_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign stream_valid_o = out_valid_q;
    assign stream_data_o  = out_q;
    assign stream_strb_o  = ostrb_q;

    always_comb begin
        word_d  = pack_q;
        wstrb_d = pstrb_q;
        if (!ctrl_q.enable) begin
            word_d  = cast_data_i;
            wstrb_d = cast_strb_i;
        end else begin
            for (int s = 0; s < PACK_RATIO; s++) begin
                if (slot_q == SLOT_W'(s)) begin
                    word_d[s*NARROW_W +: NARROW_W]  = cast_data_i[NARROW_W-1:0];
                    wstrb_d[s*NARROW_B +: NARROW_B] = cast_strb_i[NARROW_B-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            rem_q       <= '0;
            slot_q      <= '0;
            pack_q      <= '0;
            pstrb_q     <= '0;
            out_q       <= '0;
            ostrb_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            rem_q       <= '0;
            slot_q      <= '0;
            pack_q      <= '0;
            pstrb_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && stream_ready_i) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ctrl_q  <= cfg_i;
                        rem_q   <= len_i;
                        slot_q  <= '0;
                        pack_q  <= '0;
                        pstrb_q <= '0;
                        state_q <= (len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        rem_q <= rem_q - LEN_WIDTH'(1);
                        // A new word overrides the valid-clear above.
                        if (completes) begin
                            out_q       <= word_d;
                            ostrb_q     <= wstrb_d;
                            out_valid_q <= 1'b1;
                            slot_q      <= '0;
                            pack_q      <= '0;
                            pstrb_q     <= '0;
                        end else begin
                            slot_q  <= slot_q + SLOT_W'(1);
                            pack_q  <= word_d;
                            pstrb_q <= wstrb_d;
                        end
                        if (last_beat) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_q || stream_ready_i) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
